// File: rtl/amrxdemod.sv
// amrxdemod: non-coherent AM receiver. Square-wave quadrature NCO mixer, I/Q integrate-and-dump,
// envelope estimate, optional DC block (AMRXDEMOD_DC_BLOCK_EN), Q8.8 gain, sigma-delta audio bit.

module amrxdemod_iad #(
  parameter int AW = 12
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_hold,
  input  logic          i_restart,
  input  logic          i_dump,
  input  logic [1:0]    i_p,
  output logic [AW-1:0] o_d
);
  logic [AW-1:0] acc, pext, nxt;

  assign pext = {{(AW-2){i_p[1]}}, i_p};
  assign nxt  = acc + pext;

  // restart folds the current product in, so a cleared window still spans 2^LG samples
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc <= '0;
      o_d <= '0;
    end else if (i_hold) begin
      acc <= '0;
    end else if (i_restart) begin
      acc <= pext;
    end else if (i_dump) begin
      o_d <= nxt;
      acc <= '0;
    end else begin
      acc <= nxt;
    end
  end
endmodule

module amrxdemod #(
  parameter int          CLOCK_FREQUENCY_HZ = 36_000_000,
  parameter logic [31:0] DEFAULT_STEP       = 32'h2000_0000,
  parameter int          LGDECIMATE         = 10
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_rx_en,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  input  logic [1:0]  i_rf_data,
  output logic        o_audio_ce,
  output logic [15:0] o_audio,
  output logic        o_pwm
);
  localparam int AW     = LGDECIMATE + 2;
  localparam int YW     = AW + 1;
  localparam int PW     = YW + 17;
  localparam int STAGES = 3;

  typedef struct packed {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data;
  } wb_req_t;

  wb_req_t req;
  logic    stb, clr, hold, dump;
  logic    unused_ok;

  assign req        = '{we: i_wb_we, addr: i_wb_addr, data: i_wb_data};
  assign stb        = i_wb_cyc & i_wb_stb;
  assign clr        = stb & req.we & (req.addr == 2'd1) & req.data[31];
  assign hold       = ~i_rx_en;
  assign o_wb_stall = 1'b0;
  assign unused_ok  = &{1'b0, i_wb_sel, (CLOCK_FREQUENCY_HZ > 0)};

  logic [31:0]           step;
  logic [15:0]           gain;
  logic [AW-1:0]         mag;
  logic [STAGES:0]       vld_pipe;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      step      <= DEFAULT_STEP;
      gain      <= 16'h0100;
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= stb;
      if (stb) begin
        case (req.addr)
          2'd0:    o_wb_data <= step;
          2'd1:    o_wb_data <= {16'h0, gain};
          2'd2:    o_wb_data <= {16'h0, o_audio};
          default: o_wb_data <= {{(32-AW){1'b0}}, mag};
        endcase
        if (req.we) begin
          case (req.addr)
            2'd0:    step <= req.data;
            2'd1:    gain <= req.data[15:0];
            default: ;
          endcase
        end
      end
    end
  end

  // NCO and window counter; a filter reset restarts from phase 0 on the write cycle itself
  logic [31:0]           phase, ph_eff;
  logic [LGDECIMATE-1:0] cnt;
  logic [1:0]            samp, neg;
  logic [1:0][1:0]       prod;
  logic [1:0][AW-1:0]    dsum, absv;

  assign ph_eff = clr ? 32'h0 : phase;
  assign neg    = {ph_eff[31], ph_eff[31] ^ ph_eff[30]};
  assign dump   = i_rx_en & ~clr & (&cnt);

  always_comb begin
    samp = 2'b00;
    case (i_rf_data)
      2'b11:   samp = 2'b01;
      2'b00:   samp = 2'b11;
      default: samp = 2'b00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      phase <= '0;
      cnt   <= '0;
    end else if (hold) begin
      phase <= '0;
      cnt   <= '0;
    end else begin
      phase <= ph_eff + step;
      cnt   <= clr ? LGDECIMATE'(1) : cnt + LGDECIMATE'(1);
    end
  end

  // lane 0 = I (cos), lane 1 = Q (sin)
  for (genvar l = 0; l < 2; l++) begin : g_lane
    assign prod[l] = neg[l] ? (2'b00 - samp) : samp;
    assign absv[l] = dsum[l][AW-1] ? (AW'(0) - dsum[l]) : dsum[l];
    amrxdemod_iad #(.AW(AW)) u_iad (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_hold    (hold),
      .i_restart (clr),
      .i_dump    (dump),
      .i_p       (prod[l]),
      .o_d       (dsum[l])
    );
  end

  logic [AW-1:0] mx, mn, mag_nxt;
  assign mx      = (absv[0] > absv[1]) ? absv[0] : absv[1];
  assign mn      = (absv[0] > absv[1]) ? absv[1] : absv[0];
  assign mag_nxt = mx + (mn >> 1);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)      vld_pipe <= '0;
    else if (hold | clr) vld_pipe <= '0;
    else                 vld_pipe <= {vld_pipe[STAGES-1:0], dump};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)       mag <= '0;
    else if (vld_pipe[0]) mag <= mag_nxt;
  end

  logic signed [YW-1:0] y;
`ifdef AMRXDEMOD_DC_BLOCK_EN
  localparam int DW = AW + 9;
  logic signed [DW-1:0] avg, diff;
  // avg carries 8 fraction bits; leak rate 1/256 per sample
  assign diff = $signed({1'b0, mag, 8'h00}) - avg;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      avg <= '0;
      y   <= '0;
    end else if (clr) begin
      avg <= '0;
    end else if (vld_pipe[1]) begin
      y   <= diff[DW-1:8];
      avg <= avg + (diff >>> 8);
    end
  end
`else
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)       y <= '0;
    else if (vld_pipe[1]) y <= $signed({1'b0, mag});
  end
`endif

  logic signed [PW-1:0] gprod, gsh;
  logic                 ovf;
  logic [15:0]          audio_nxt;

  assign gprod     = y * $signed({1'b0, gain});
  assign gsh       = gprod >>> 8;
  assign ovf       = ~((&gsh[PW-1:15]) | ~(|gsh[PW-1:15]));
  assign audio_nxt = ovf ? (gsh[PW-1] ? 16'h8000 : 16'h7FFF) : gsh[15:0];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)       o_audio <= '0;
    else if (vld_pipe[2]) o_audio <= audio_nxt;
  end

  assign o_audio_ce = vld_pipe[STAGES];

  // offset-binary first-order sigma-delta, carry is the output bit
  logic [15:0] sd_acc;
  logic [16:0] sd_sum;
  assign sd_sum = {1'b0, sd_acc} + {1'b0, ~o_audio[15], o_audio[14:0]};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sd_acc <= '0;
      o_pwm  <= 1'b0;
    end else begin
      sd_acc <= sd_sum[15:0];
      o_pwm  <= sd_sum[16];
    end
  end
endmodule
